// File: rtl/mem_bus_master.sv
// Burst initiator for the valid/ready single-port memory bus.
// Sequences host bursts into single-beat slave accesses with address wrap and a ready timeout.
module mem_bus_master #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wd_valid,
    input  logic [WIDTH-1:0]      wd_data,
    output logic                  wd_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  done,
    output logic                  err,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready
);

    localparam int BEATS_W = LEN_WIDTH + 1;
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, REQ, GAP} state_t;

    state_t                r_state,     w_state_nxt;
    logic                  r_wr,        w_wr_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
    logic [BEATS_W-1:0]    r_beats,     w_beats_nxt;
    logic                  r_err_flag,  w_err_flag_nxt;
    logic [TIMER_W-1:0]    r_timer,     w_timer_nxt;
    logic [WIDTH-1:0]      r_wdata,     w_wdata_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [WIDTH-1:0]      r_rsp_data,  w_rsp_data_nxt;
    logic                  r_done,      w_done_nxt;
    logic                  r_err,       w_err_nxt;
    logic                  r_valid;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_state_nxt     = r_state;
        w_wr_nxt        = r_wr;
        w_addr_nxt      = r_addr;
        w_beats_nxt     = r_beats;
        w_err_flag_nxt  = r_err_flag;
        w_timer_nxt     = r_timer;
        w_wdata_nxt     = r_wdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_wr_nxt       = cmd_wr;
                    w_addr_nxt     = cmd_addr;
                    w_beats_nxt    = BEATS_W'(cmd_len) + BEATS_W'(1);
                    w_err_flag_nxt = 1'b0;
                    w_timer_nxt    = '0;
                    w_state_nxt    = cmd_wr ? LOAD : REQ;
                end
            end
            LOAD: begin
                if (wd_valid) begin
                    w_wdata_nxt = wd_data;
                    w_timer_nxt = '0;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (ready) begin
                    if (!r_wr) begin
                        w_rsp_data_nxt  = rdata;
                        w_rsp_valid_nxt = 1'b1;
                    end
                    w_beats_nxt = r_beats - BEATS_W'(1);
                    w_addr_nxt  = (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);
                    w_state_nxt = GAP;
                end else if (r_timer == TIMER_W'(TIMEOUT - 1)) begin
                    w_err_flag_nxt = 1'b1;
                    w_beats_nxt    = '0;
                    w_state_nxt    = GAP;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end
            GAP: begin
                // A ready still high from the finished beat must not complete the next one.
                if (!ready) begin
                    if (r_beats != '0) begin
                        w_timer_nxt = '0;
                        w_state_nxt = r_wr ? LOAD : REQ;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = r_err_flag;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_beats     <= '0;
            r_err_flag  <= 1'b0;
            r_timer     <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr        <= w_wr_nxt;
            r_addr      <= w_addr_nxt;
            r_beats     <= w_beats_nxt;
            r_err_flag  <= w_err_flag_nxt;
            r_timer     <= w_timer_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_valid     <= (w_state_nxt == REQ);
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign wd_ready  = (r_state == LOAD);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign done      = r_done;
    assign err       = r_err;
    assign valid     = r_valid;
    assign wr_rd     = r_wr;
    assign addr      = r_addr;
    assign wdata     = r_wdata;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: directed bursts against a small memory slave,
// expected accesses/responses/dones queued by stimulus and checked by a negedge monitor.
module tb_mem_bus_master;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int LEN_WIDTH  = 4;
    localparam int TIMEOUT    = 16;

    logic                  clk;
    logic                  rst;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wd_valid;
    logic [WIDTH-1:0]      wd_data;
    logic                  wd_ready;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  done;
    logic                  err;
    logic                  valid;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH-1:0]      rdata;
    logic                  ready;

    mem_bus_master #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH(LEN_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .err(err),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: answers ready one cycle after each sampled request; ready_en=0 models a hung slave.
    logic             ready_en;
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (valid && ready_en) begin
            ready <= 1'b1;
            if (wr_rd) mem[addr] <= wdata;
            else       rdata     <= mem[addr];
        end else begin
            ready <= 1'b0;
        end
    end

    typedef struct packed {logic wr; logic [ADDR_WIDTH-1:0] addr; logic [WIDTH-1:0] data;} acc_t;
    typedef struct packed {logic [WIDTH-1:0] data; int cyc;} rsp_t;
    typedef struct packed {logic err; int cyc;} done_t;

    acc_t  exp_acc [$];
    rsp_t  exp_rsp [$];
    done_t exp_done[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_acc(input logic wr, input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        acc_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_acc.push_back(e);
    endtask

    task automatic push_rsp(input logic [WIDTH-1:0] d, input int c);
        rsp_t e;
        e.data = d; e.cyc = c;
        exp_rsp.push_back(e);
    endtask

    task automatic push_done(input logic e_err, input int c);
        done_t e;
        e.err = e_err; e.cyc = c;
        exp_done.push_back(e);
    endtask

    // Monitor: pops and compares whenever the DUT presents an access, a response or a done.
    logic                            m_prev_valid = 1'b0;
    logic                            m_prev_ready = 1'b0;
    logic [WIDTH+ADDR_WIDTH:0]       m_hold = '0;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
            end else begin
                rsp_t r;
                r = exp_rsp.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(r.data));
                if (r.cyc >= 0) check("rsp_cycle", cyc, r.cyc);
            end
        end
        if (done === 1'b1) begin
            if (exp_done.size() == 0) begin
                check("done_unexpected", {31'd0, err}, 32'hFFFF_FFFF);
            end else begin
                done_t d;
                d = exp_done.pop_front();
                check("done_err", {31'd0, err}, {31'd0, d.err});
                check("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
                if (d.cyc >= 0) check("done_cycle", cyc, d.cyc);
            end
        end
        if (valid === 1'b1 && !m_prev_valid) begin
            check("acc_ready_low", {31'd0, m_prev_ready}, 32'd0);
            if (exp_acc.size() == 0) begin
                check("acc_unexpected", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                acc_t a;
                a = exp_acc.pop_front();
                check("acc_wr", {31'd0, wr_rd}, {31'd0, a.wr});
                check("acc_addr", 32'(addr), 32'(a.addr));
                if (a.wr) check("acc_wdata", 32'(wdata), 32'(a.data));
            end
            m_hold <= {wr_rd, addr, wdata};
        end else if (valid === 1'b1) begin
            check("acc_hold", 32'({wr_rd, addr, wdata}), 32'(m_hold));
        end
        m_prev_valid <= (valid === 1'b1);
        m_prev_ready <= (ready === 1'b1);
    end

    // Returns just after the accept edge with acc = that edge's cycle number.
    task automatic send_cmd(input logic wr, input logic [ADDR_WIDTH-1:0] a,
                            input logic [LEN_WIDTH-1:0] len, input bit keep, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = len;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [WIDTH-1:0] d, input int stall);
        int n;
        n = 0;
        @(negedge clk);
        while (wd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wd_ready_wait", {31'd0, wd_ready}, 32'd1);
        repeat (stall) begin
            check("stall_valid", {31'd0, valid}, 32'd0);
            check("stall_wd_ready", {31'd0, wd_ready}, 32'd1);
            @(negedge clk);
        end
        wd_valid = 1'b1;
        wd_data  = d;
        @(negedge clk);
        wd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_acc.size() + exp_rsp.size() + exp_done.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_acc.size() + exp_rsp.size() + exp_done.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, a1, a2, nv, nr;
        rst = 1'b1; ready_en = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_wd_ready", {31'd0, wd_ready}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_wr_rd", {31'd0, wr_rd}, 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        // Single write with wd_valid held high, then single read of the same word.
        wd_valid = 1'b1; wd_data = 16'hA5A5;
        push_acc(1'b1, 5'd5, 16'hA5A5);
        send_cmd(1'b1, 5'd5, 4'd0, 1'b0, a);
        push_done(1'b0, a + 5);
        wait_idle();
        wd_valid = 1'b0;

        send_cmd(1'b0, 5'd5, 4'd0, 1'b0, a);
        push_acc(1'b0, 5'd5, 16'h0);
        push_rsp(16'hA5A5, a + 2);
        push_done(1'b0, a + 4);
        wait_idle();

        // Four-beat write wrapping 30,31,0,1, then read it back.
        send_cmd(1'b1, 5'd30, 4'd3, 1'b0, a);
        push_acc(1'b1, 5'd30, 16'd1);
        push_acc(1'b1, 5'd31, 16'd2);
        push_acc(1'b1, 5'd0,  16'd3);
        push_acc(1'b1, 5'd1,  16'd4);
        push_done(1'b0, a + 20);
        for (int i = 1; i <= 4; i++) feed(WIDTH'(i), 0);
        wait_idle();

        send_cmd(1'b0, 5'd30, 4'd3, 1'b0, a);
        push_acc(1'b0, 5'd30, 16'h0);
        push_acc(1'b0, 5'd31, 16'h0);
        push_acc(1'b0, 5'd0,  16'h0);
        push_acc(1'b0, 5'd1,  16'h0);
        for (int i = 0; i < 4; i++) push_rsp(WIDTH'(i + 1), a + 2 + 4 * i);
        push_done(1'b0, a + 16);
        wait_idle();

        // Two-beat write with a 5-cycle write-data stall before each beat.
        send_cmd(1'b1, 5'd10, 4'd1, 1'b0, a);
        push_acc(1'b1, 5'd10, 16'h1234);
        push_acc(1'b1, 5'd11, 16'h5678);
        push_done(1'b0, a + 20);
        feed(16'h1234, 5);
        feed(16'h5678, 5);
        wait_idle();

        send_cmd(1'b0, 5'd10, 4'd1, 1'b0, a);
        push_acc(1'b0, 5'd10, 16'h0);
        push_acc(1'b0, 5'd11, 16'h0);
        push_rsp(16'h1234, a + 2);
        push_rsp(16'h5678, a + 6);
        push_done(1'b0, a + 8);
        wait_idle();

        // Hung slave: first beat times out after 16 request cycles, burst ends with err.
        ready_en = 1'b0;
        send_cmd(1'b0, 5'd7, 4'd2, 1'b0, a);
        push_acc(1'b0, 5'd7, 16'h0);
        push_done(1'b1, a + 17);
        nv = 0; nr = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
            if (rsp_valid === 1'b1) nr++;
        end
        check("timeout_valid_cycles", nv, 16);
        check("timeout_rsp_count", nr, 0);
        wait_idle();
        ready_en = 1'b1;

        // Back-to-back: cmd_valid stays high; second command taken on the done cycle.
        send_cmd(1'b0, 5'd30, 4'd0, 1'b1, a1);
        push_acc(1'b0, 5'd30, 16'h0);
        push_rsp(16'd1, a1 + 2);
        push_done(1'b0, a1 + 4);
        send_cmd(1'b0, 5'd5, 4'd0, 1'b0, a2);
        check("b2b_accept_cycle", a2, a1 + 5);
        push_acc(1'b0, 5'd5, 16'h0);
        push_rsp(16'hA5A5, a2 + 2);
        push_done(1'b0, a2 + 4);
        wait_idle();

        // Reset during the request of beat 2 of 4, then a fresh read.
        send_cmd(1'b0, 5'd30, 4'd3, 1'b0, a);
        push_acc(1'b0, 5'd30, 16'h0);
        push_acc(1'b0, 5'd31, 16'h0);
        push_rsp(16'd1, a + 2);
        repeat (5) @(negedge clk);
        check("pre_rst_valid", {31'd0, valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {31'd0, valid}, 32'd0);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_rst_done", {31'd0, done}, 32'd0);
        check("post_rst_err", {31'd0, err}, 32'd0);
        check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        send_cmd(1'b0, 5'd10, 4'd0, 1'b0, a);
        push_acc(1'b0, 5'd10, 16'h0);
        push_rsp(16'h1234, a + 2);
        push_done(1'b0, a + 4);
        wait_idle();

        repeat (5) @(negedge clk);
        check("final_queues_empty", exp_acc.size() + exp_rsp.size() + exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator for the team's valid/ready single-port memory bus; drives valid, wr_rd, addr and wdata into the memory slave and collects rdata.
- Accepts one burst command at a time from a host-side command port; writes take per-beat data from a write-data port, reads return per-beat data on a response port.
- Sits between testbench or CPU-side request logic and the memory slave; adds burst sequencing, address wrap and a ready timeout.

Parameters:
- WIDTH, 16, data width; must match the slave.
- DEPTH, 32, number of memory words; addresses wrap modulo DEPTH.
- ADDR_WIDTH, 5, address width, equal to clog2(DEPTH).
- LEN_WIDTH, 4, width of cmd_len; a burst is cmd_len+1 beats (1..16).
- TIMEOUT, 16, number of REQ cycles with ready low before the beat is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle; equals (state==IDLE)
- cmd_wr  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_WIDTH  burst start address
- cmd_len  in  LEN_WIDTH  beats minus one
- wd_valid  in  1  write beat data present
- wd_data  in  WIDTH  write beat data
- wd_ready  out  1  write data consumed this cycle; equals (state==LOAD)
- rsp_valid  out  1  one-cycle pulse per completed read beat
- rsp_data  out  WIDTH  read beat data, valid with rsp_valid
- done  out  1  one-cycle pulse at burst end
- err  out  1  valid with done; 1=burst aborted by timeout
- valid  out  1  bus request to slave
- wr_rd  out  1  bus direction, 1=write
- addr  out  ADDR_WIDTH  bus address
- wdata  out  WIDTH  bus write data
- rdata  in  WIDTH  bus read data from slave
- ready  in  1  bus completion from slave

Behaviour:
- All outputs are registered. On reset: state=IDLE and every output is 0, except cmd_ready, which is 1 because it is combinational on state. Internal counters clear.
- Reset mid-burst: abandon at once. valid drops the next cycle. No done or rsp pulse is produced.
- FSM states: IDLE, LOAD, REQ, GAP.
- IDLE: on cmd_valid, latch wr, addr and beats=cmd_len+1, clear err_flag, then go to LOAD if cmd_wr else REQ. cmd_valid is ignored in every other state.
- LOAD: wd_ready=1. On wd_valid, latch wd_data into wdata and go to REQ. There is no timeout in LOAD.
- REQ: valid=1, with wr_rd, addr and wdata held stable. The timer clears on entry and increments each REQ cycle with ready=0.
  - ready=1: beat completes. If reading, rsp_data<=rdata and rsp_valid<=1. Then beats-=1, addr<=(addr+1) mod DEPTH (DEPTH-1 wraps to 0), valid<=0, go to GAP.
  - timer reaches TIMEOUT-1 with ready=0: valid<=0, err_flag<=1, beats<=0, go to GAP.
- GAP: valid=0. Wait until ready is sampled 0. This prevents a stale ready from completing the next beat. On exit:
  - beats>0: go to LOAD (write) or REQ (read).
  - beats==0: done<=1, err<=err_flag, go to IDLE.
- A completed beat produces exactly one slave access per address. A duplicate slave sample of the same held beat is harmless: it is an identical write or read.
- Single read latency against the slave, counting edges after the command-accept edge: valid high cycles 1-2, rsp_valid at cycle 2, done at cycle 4, cmd_ready high again at cycle 4.
- Read burst beat period is 4 cycles. Write beat period is 4 cycles plus LOAD wait, minimum 1.
- The host keeps cmd_addr, cmd_len and cmd_wr valid only during the accept cycle; the block latches them.

Test Plan:
- Single write then read: write addr 5 data 16'hA5A5 with wd_valid held high, then read addr 5. Expect one wr_rd=1 access at addr 5, done with err=0, then rsp_data=16'hA5A5 at cycle 2 and done at cycle 4.
- Write burst with wrap: cmd_addr=30, cmd_len=3, data 1,2,3,4. Slave accesses go to addr 30,31,0,1. Read back the same burst and expect rsp_data 1,2,3,4 on four pulses, then a single done.
- Write-data stall: write burst len 1 with wd_valid low for 5 cycles before each beat. valid must stay 0 during the stall and wd_ready stay 1. Contents are correct afterwards.
- Timeout: tie ready=0 and issue a read with len 2. Expect valid high for exactly 16 cycles, then low, no rsp_valid, done=1 with err=1, and cmd_ready back to 1.
- Back-to-back commands: cmd_valid held high with two queued commands. The second is accepted only in the cycle done pulses. No valid is asserted while ready is still 1 from the previous beat.
- Reset mid-burst: assert rst during REQ of beat 2 of 4. Next cycle valid=0 and cmd_ready=1; there is no done or err pulse. A fresh command then completes normally.
